// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirect flushes, memory-wait freeze,
// plus saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_raddr,
  input  logic [4:0]       id_rs2_raddr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_reg_waddr,
  input  logic             ex_reg_wena,
  input  logic             ex_mem_rena,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             pipelineFlush,
  output logic             idex_hazarded,
  output logic             pipe_freeze,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state    | meaning
  // RUN      | normal issue; redirect / load-use / mem_busy evaluated by priority
  // MEM_WAIT | pipe frozen on mem_busy; evaluates as RUN once memory is ready
  // FLUSH    | post-redirect bubble cycles counted down by fc
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [2:0] FC_INIT    = 3'(FLUSH_CYCLES);

  logic [1:0] state, state_nxt;
  logic [2:0] fc, fc_nxt;
  logic       lu;
  logic       redirect_acc;

  assign lu = ex_mem_rena && ex_reg_wena && (ex_reg_waddr != 5'd0) &&
              ((id_rs1_used && (id_rs1_raddr == ex_reg_waddr)) ||
               (id_rs2_used && (id_rs2_raddr == ex_reg_waddr)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      fc    <= 3'd0;
    end else begin
      state <= state_nxt;
      fc    <= fc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fc_nxt       = fc;
    redirect_acc = 1'b0;
    case (state)
      S_RUN, S_MEM_WAIT: begin
        if (mem_busy) begin
          state_nxt = S_MEM_WAIT;
        end else if (ex_redirect) begin
          redirect_acc = 1'b1;
          if (FC_INIT != 3'd0) begin
            state_nxt = S_FLUSH;
            fc_nxt    = FC_INIT;
          end else begin
            state_nxt = S_RUN;
          end
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        // fc is frozen along with the rest of the pipe while memory stalls
        if (!mem_busy) begin
          if (fc <= 3'd1) begin
            state_nxt = S_RUN;
            fc_nxt    = 3'd0;
          end else begin
            fc_nxt = fc - 3'd1;
          end
        end
      end
      default: begin
        state_nxt = S_RUN;
        fc_nxt    = 3'd0;
      end
    endcase
  end

  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    pipelineFlush = 1'b0;
    idex_hazarded = 1'b0;
    pipe_freeze   = 1'b0;
    if (rst) begin
      if (mem_busy) begin
        pipe_freeze = 1'b1;
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
      end else if (state == S_FLUSH || ex_redirect) begin
        ifid_flush    = 1'b1;
        pipelineFlush = 1'b1;
      end else if (lu) begin
        idex_hazarded = 1'b1;
        pc_stall      = 1'b1;
        ifid_stall    = 1'b1;
      end
    end
  end

  assign hz_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((idex_hazarded || pipe_freeze) && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_acc && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand sequences for multi-cycle cases,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_hazard_ctrl;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    id_rs1_raddr, id_rs2_raddr, ex_reg_waddr;
  logic          id_rs1_used, id_rs2_used, ex_reg_wena, ex_mem_rena, ex_redirect, mem_busy;
  logic          pc_stall, ifid_stall, ifid_flush, pipelineFlush, idex_hazarded, pipe_freeze;
  logic [1:0]    hz_state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_reg_waddr(ex_reg_waddr), .ex_reg_wena(ex_reg_wena), .ex_mem_rena(ex_mem_rena),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .pipelineFlush(pipelineFlush), .idex_hazarded(idex_hazarded), .pipe_freeze(pipe_freeze),
    .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: remaining flush bubbles, whether the last edge froze on memory, event counts
  int m_flush_left;
  bit m_wait;
  int m_stall, m_flush;

  // ctrl vector bit order: {pc_stall, ifid_stall, ifid_flush, pipelineFlush, idex_hazarded, pipe_freeze}
  function automatic logic [5:0] ctrl_act();
    return {pc_stall, ifid_stall, ifid_flush, pipelineFlush, idex_hazarded, pipe_freeze};
  endfunction

  function automatic logic [5:0] model_ctrl();
    logic hit;
    hit = ex_mem_rena && ex_reg_wena && (ex_reg_waddr != 0) &&
          ((id_rs1_used && id_rs1_raddr == ex_reg_waddr) ||
           (id_rs2_used && id_rs2_raddr == ex_reg_waddr));
    if (!rst)                        return 6'b000000;
    if (mem_busy)                    return 6'b110001;
    if (m_flush_left > 0)            return 6'b001100;
    if (ex_redirect)                 return 6'b001100;
    if (hit)                         return 6'b110010;
    return 6'b000000;
  endfunction

  function automatic int model_hz();
    if (m_flush_left > 0) return 2;
    if (m_wait)           return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_flush_left = 0;
    m_wait       = 1'b0;
    m_stall      = 0;
    m_flush      = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs1_raddr = 0; id_rs2_raddr = 0; ex_reg_waddr = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_reg_wena = 0; ex_mem_rena = 0;
    ex_redirect = 0; mem_busy = 0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    ex_mem_rena = 1; ex_reg_wena = 1; ex_reg_waddr = r;
    id_rs1_used = 1; id_rs1_raddr = r;
  endtask

  // compare every observable against the model at the falling edge
  task automatic sample();
    @(negedge clk);
    check("ctrl", 32'(ctrl_act()), 32'(model_ctrl()));
    check("hz_state", 32'(hz_state), 32'(model_hz()));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    check("invariant", 32'((idex_hazarded & (pipelineFlush | pipe_freeze)) |
                           (ifid_flush & ifid_stall)), 32'd0);
  endtask

  task automatic advance();
    logic [5:0] e;
    e = model_ctrl();
    if (rst) begin
      if ((e[1] || e[0]) && m_stall < CMAX) m_stall++;
      if (m_flush_left > 0) begin
        if (!mem_busy) m_flush_left--;
        m_wait = 1'b0;
      end else if (mem_busy) begin
        m_wait = 1'b1;
      end else begin
        m_wait = 1'b0;
        if (ex_redirect) begin
          if (m_flush < CMAX) m_flush++;
          m_flush_left = FC;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, waddr;
    logic       rs1_used, rs2_used, wena, rena, redirect, busy;
    logic [5:0] exp_ctrl;
    string      name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    set_idle();
    model_reset();
    vecs[0] = '{5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, 6'b110010, "lu_rs1"};
    vecs[1] = '{5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 0, 0, 6'b000000, "load_x0"};
    vecs[2] = '{5'd3, 5'd7, 5'd7, 1, 1, 1, 1, 0, 0, 6'b110010, "lu_rs2"};
    vecs[3] = '{5'd9, 5'd0, 5'd9, 0, 0, 1, 1, 0, 0, 6'b000000, "rs1_unused"};
    vecs[4] = '{5'd9, 5'd0, 5'd9, 1, 0, 0, 1, 0, 0, 6'b000000, "no_wena"};
    vecs[5] = '{5'd9, 5'd0, 5'd9, 1, 0, 1, 0, 0, 0, 6'b000000, "alu_op"};
    vecs[6] = '{5'd4, 5'd0, 5'd4, 1, 0, 1, 1, 1, 0, 6'b001100, "redir_over_lu"};
    vecs[7] = '{5'd4, 5'd0, 5'd4, 1, 0, 1, 1, 1, 1, 6'b110001, "busy_over_all"};
    vecs[8] = '{5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0, 0, 6'b000000, "no_match"};

    // reset values, with stimulus present to exercise output gating
    set_lu(5'd6);
    mem_busy = 1;
    #12;
    check("rst_ctrl", 32'(ctrl_act()), 32'd0);
    check("rst_hz", 32'(hz_state), 32'd0);
    check("rst_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);

    foreach (vecs[i]) begin
      do_reset();
      id_rs1_raddr = vecs[i].rs1; id_rs2_raddr = vecs[i].rs2; ex_reg_waddr = vecs[i].waddr;
      id_rs1_used = vecs[i].rs1_used; id_rs2_used = vecs[i].rs2_used;
      ex_reg_wena = vecs[i].wena; ex_mem_rena = vecs[i].rena;
      ex_redirect = vecs[i].redirect; mem_busy = vecs[i].busy;
      sample();
      check(vecs[i].name, 32'(ctrl_act()), 32'(vecs[i].exp_ctrl));
      advance();
    end

    // single-cycle load-use stall, counter 0 -> 1
    do_reset();
    set_lu(5'd5);
    sample();
    check("lu_cnt_before", 32'(stall_cnt), 32'd0);
    advance();
    set_idle();
    sample();
    check("lu_one_cycle", 32'(idex_hazarded | pc_stall | ifid_stall), 32'd0);
    check("lu_cnt_after", 32'(stall_cnt), 32'd1);
    advance();

    // redirect: flushes at t, t+1, t+2; second redirect at t+1 ignored
    do_reset();
    ex_redirect = 1;
    sample();
    check("redir_t", 32'({ifid_flush, pipelineFlush, hz_state}), 32'b1100);
    advance();
    sample();
    check("redir_t1", 32'({ifid_flush, pipelineFlush, hz_state}), 32'b1110);
    advance();
    ex_redirect = 0;
    sample();
    check("redir_t2", 32'({ifid_flush, pipelineFlush, hz_state}), 32'b1110);
    advance();
    sample();
    check("redir_t3", 32'({ifid_flush, pipelineFlush, hz_state}), 32'b0000);
    check("redir_cnt", 32'(flush_cnt), 32'd1);
    advance();

    // memory wait with redirect and load-use pending
    do_reset();
    set_lu(5'd8);
    ex_redirect = 1;
    mem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("mw_freeze", 32'({pipe_freeze, ifid_flush, pipelineFlush, idex_hazarded}), 32'b1000);
      advance();
    end
    mem_busy = 0;
    sample();
    check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    check("mw_redir_acc", 32'({ifid_flush, pipelineFlush, pipe_freeze}), 32'b110);
    advance();
    set_idle();
    sample();
    check("mw_flush_cnt", 32'(flush_cnt), 32'd1);
    advance();

    // busy inside FLUSH holds fc and suppresses flushes
    do_reset();
    ex_redirect = 1;
    sample(); advance();
    ex_redirect = 0;
    mem_busy = 1;
    for (int c = 0; c < 3; c++) begin sample(); advance(); end
    mem_busy = 0;
    for (int c = 0; c < 3; c++) begin sample(); advance(); end

    // saturation
    do_reset();
    set_lu(5'd11);
    for (int c = 0; c < 20; c++) advance();
    sample();
    check("stall_sat", 32'(stall_cnt), 32'd15);
    advance();

    // asynchronous reset mid-FLUSH
    do_reset();
    set_lu(5'd2);
    ex_redirect = 1;
    sample(); advance();
    ex_redirect = 0;
    #2;
    check("pre_rst_flush", 32'(ifid_flush), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_ctrl", 32'(ctrl_act()), 32'd0);
    check("arst_hz", 32'(hz_state), 32'd0);
    check("arst_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
    model_reset();
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      sample();
      check("arst_no_flush", 32'({ifid_flush, pipelineFlush}), 32'd0);
      advance();
    end

    // randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        id_rs1_raddr = 5'($urandom_range(0, 3));
        id_rs2_raddr = 5'($urandom_range(0, 3));
        ex_reg_waddr = 5'($urandom_range(0, 3));
        id_rs1_used  = 1'($urandom_range(0, 1));
        id_rs2_used  = 1'($urandom_range(0, 1));
        ex_reg_wena  = ($urandom_range(0, 3) != 0);
        ex_mem_rena  = ($urandom_range(0, 2) == 0);
        ex_redirect  = ($urandom_range(0, 4) == 0);
        mem_busy     = ($urandom_range(0, 3) == 0);
        sample();
        advance();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Drives the ID/EX register's `idex_hazarded` (bubble) and `pipelineFlush` inputs, plus stall/flush controls for PC, IF/ID and EX/MEM.
- Detects load-use hazards and EX-stage redirects (taken branch or jump), and freezes the pipe while data memory is busy.
- Keeps saturating stall and flush event counters for FFT kernel profiling.

Parameters:
- FLUSH_CYCLES, 1: extra bubble cycles after a redirect, for fetch latency; legal range 0..7.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- id_rs1_raddr  in  5  rs1 index of the instruction in ID
- id_rs2_raddr  in  5  rs2 index of the instruction in ID
- id_rs1_used  in  1  instruction in ID reads rs1
- id_rs2_used  in  1  instruction in ID reads rs2
- ex_reg_waddr  in  5  destination register of the instruction in EX
- ex_reg_wena  in  1  instruction in EX writes a register
- ex_mem_rena  in  1  instruction in EX is a load
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- mem_busy  in  1  data memory not ready; MEM cannot complete
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID to NOP
- pipelineFlush  out  1  squash the instruction entering ID/EX
- idex_hazarded  out  1  insert a bubble into ID/EX
- pipe_freeze  out  1  hold all stage registers, including ID/EX and EX/MEM
- hz_state  out  2  0 = RUN, 1 = MEM_WAIT, 2 = FLUSH
- stall_cnt  out  CNT_W  cycles with idex_hazarded or pipe_freeze asserted
- flush_cnt  out  CNT_W  accepted redirect events

Behaviour:
- Registered state:
  - 2-bit state
  - 3-bit flush down-counter `fc`
  - both counters
  - All are cleared asynchronously when rst = 0.
- While rst = 0, every control output is 0, hz_state = RUN and both counters read 0.
- Control outputs are combinational from the current state and inputs, so they take effect in the same cycle. Counters and state update on posedge clk.
- Load-use condition `lu` is true when all of the following hold:
  - ex_mem_rena = 1
  - ex_reg_wena = 1
  - ex_reg_waddr != 0
  - (id_rs1_used = 1 and id_rs1_raddr == ex_reg_waddr) or (id_rs2_used = 1 and id_rs2_raddr == ex_reg_waddr)
- Priority within a cycle: mem_busy > ex_redirect > lu.
- RUN state:
  - mem_busy = 1:
    - Assert pipe_freeze, pc_stall and ifid_stall.
    - Deassert all other controls.
    - Next state is MEM_WAIT.
    - A concurrent ex_redirect is not accepted; EX is frozen, so the redirect is re-presented later.
  - Else ex_redirect = 1:
    - Assert ifid_flush and pipelineFlush.
    - flush_cnt increments by 1.
    - If FLUSH_CYCLES > 0: next state is FLUSH and fc is loaded with FLUSH_CYCLES.
    - Otherwise stay in RUN.
    - `lu` is ignored because the ID instruction is squashed.
  - Else if `lu`:
    - Assert idex_hazarded, pc_stall and ifid_stall for exactly one cycle.
    - The load moves to MEM, so `lu` clears next cycle without further action.
- MEM_WAIT state:
  - pipe_freeze, pc_stall and ifid_stall stay asserted while mem_busy = 1.
  - On the first cycle with mem_busy = 0, outputs evaluate as in RUN on the same cycle.
  - Next state is then taken from the RUN rules.
- FLUSH state:
  - Assert ifid_flush and pipelineFlush.
  - fc decrements each cycle; return to RUN when fc == 1 at the clock edge.
  - ex_redirect and `lu` are ignored; EX and ID hold bubbles.
  - mem_busy = 1 in FLUSH:
    - Assert pipe_freeze, pc_stall and ifid_stall, and suppress the flushes.
    - fc holds its value; state stays FLUSH.
    - Flushing resumes when mem_busy drops.
- stall_cnt increments on every clock edge where idex_hazarded or pipe_freeze is 1.
- Both counters saturate at all-ones and never wrap.
- Reset taken mid-stall or mid-flush returns the block to RUN with fc = 0 immediately, asynchronously.
- Invariants:
  - idex_hazarded is never asserted in the same cycle as pipelineFlush or pipe_freeze.
  - ifid_flush is never asserted in the same cycle as ifid_stall.

Test Plan:
- Load-use on rs1:
  - Stimulus: ex_mem_rena = 1, ex_reg_wena = 1, ex_reg_waddr = 5, id_rs1_used = 1, id_rs1_raddr = 5, for one cycle.
  - Required: idex_hazarded, pc_stall and ifid_stall are 1 for exactly that cycle; stall_cnt goes 0 -> 1.
- Load to x0:
  - Stimulus: same as above but ex_reg_waddr = 0 = id_rs2_raddr with id_rs2_used = 1.
  - Required: no stall; stall_cnt stays 0.
- Redirect with FLUSH_CYCLES = 2:
  - Stimulus: ex_redirect pulse in cycle t.
  - Required: ifid_flush and pipelineFlush are 1 in cycles t, t+1 and t+2, and 0 at t+3; hz_state goes 2 then back to 0; flush_cnt = 1. A second ex_redirect at t+1 does not increment flush_cnt.
- Memory wait:
  - Stimulus: mem_busy = 1 for 3 cycles, with ex_redirect = 1 and `lu` also true.
  - Required: pipe_freeze is 1 for those 3 cycles; no flush asserted; stall_cnt = 3. When mem_busy drops, the redirect is accepted that same cycle.
- Saturation:
  - Stimulus: CNT_W = 4, hold `lu` stimulus for 20 cycles.
  - Required: stall_cnt stops at 15.
- Async reset mid-FLUSH:
  - Stimulus: assert rst = 0 between clock edges while in FLUSH.
  - Required: all outputs 0 immediately and hz_state = 0; after release, no residual flush.
